// File: rtl/multi_edge_strobe_if.sv
// Bundle of the enable/mode/input/clear controls and the strobe/pending/level/irq
// status lines of the multi-channel edge detector.
interface multi_edge_strobe_if #(
    parameter int CHANNELS = 8
);
    logic                    enable;
    logic [2*CHANNELS-1:0]   mode;
    logic [CHANNELS-1:0]     signal;
    logic [CHANNELS-1:0]     clear;
    logic [CHANNELS-1:0]     edge_strb;
    logic [CHANNELS-1:0]     pending;
    logic [CHANNELS-1:0]     level;
    logic                    irq;

    // Driver side: owns the controls and the raw input lines.
    modport master (
        output enable, mode, signal, clear,
        input  edge_strb, pending, level, irq
    );

    // Detector side: consumes the controls, produces status.
    modport slave (
        input  enable, mode, signal, clear,
        output edge_strb, pending, level, irq
    );
endinterface

// File: rtl/multi_edge_strobe.sv
// N-channel edge detector: each asynchronous input is synchronised, debounced,
// and turned into a one-cycle strobe on its rising, falling or both edges.
// Strobes set sticky write-1-to-clear pending flags; irq is the OR of them.
module multi_edge_strobe #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_edge_strobe_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Per-channel edge selection: mode bit 0 enables rise, bit 1 enables fall.
    function automatic logic edge_hit(input logic [1:0] m, input logic r, input logic f);
        return (m[0] & r) | (m[1] & f);
    endfunction

    logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_out;
    logic [CNT_W-1:0]    cnt_p1  [CHANNELS];
    logic [CHANNELS-1:0] level_p1;
    logic [CHANNELS-1:0] level_dly_p2;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] strb_d;
    logic [CHANNELS-1:0] strb_p3;
    logic [CHANNELS-1:0] pending_p4;

    // Stage 0: plain flop chain bringing the raw lines into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
        end else begin
            sync_p0[0] <= bus.signal;
            for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

    // Stage 1: accept a new level only after it has persisted DEBOUNCE cycles;
    // any return to the current level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_p1 <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync_out[i] == level_p1[i]) begin
                    cnt_p1[i] <= '0;
                end else if (cnt_p1[i] == CNT_LAST) begin
                    level_p1[i] <= sync_out[i];
                    cnt_p1[i]   <= '0;
                end else begin
                    cnt_p1[i] <= cnt_p1[i] + CNT_ONE;
                end
            end
        end
    end

    // Stage 2: delayed copy of the filtered level for edge extraction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_dly_p2 <= '0;
        else       level_dly_p2 <= level_p1;
    end

    assign rise = level_p1 & ~level_dly_p2;
    assign fall = ~level_p1 & level_dly_p2;

    // Edge qualification by global enable and per-channel mode; edges are only
    // one cycle wide, so edges seen while disabled or masked are simply lost.
    always_comb begin
        strb_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            strb_d[i] = bus.enable & edge_hit(bus.mode[2*i +: 2], rise[i], fall[i]);
        end
    end

    // Stage 3: registered one-cycle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) strb_p3 <= '0;
        else       strb_p3 <= strb_d;
    end

    // Stage 4: sticky pending flags; a strobe wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_p4 <= '0;
        else       pending_p4 <= strb_p3 | (pending_p4 & ~bus.clear);
    end

    assign bus.edge_strb = strb_p3;
    assign bus.pending   = pending_p4;
    assign bus.level     = level_p1;
    assign bus.irq       = |pending_p4;

endmodule

// File: tb/tb_multi_edge_strobe.sv
// Directed bench for multi_edge_strobe with 4 channels, 2 sync stages, debounce 4.
module tb_multi_edge_strobe;

    localparam int CH = 4;

    logic clk;
    logic reset;
    int   total;
    int   passes;

    multi_edge_strobe_if #(.CHANNELS(CH)) bus ();

    multi_edge_strobe #(
        .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run n cycles, recording the first cycle (1-based) and number of cycles
    // in which edge_strb[ch] is high.
    task automatic run_watch(input int ch, input int n, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (bus.edge_strb[ch]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
    endtask

    initial begin
        int first, cnt, first2, cnt2;
        int hits [$];
        int abs_t;

        total  = 0;
        passes = 0;
        reset  = 1'b1;
        bus.enable = 1'b1;
        bus.mode   = 8'hF9;       // ch0 rise, ch1 fall, ch2 both, ch3 both
        bus.signal = 4'b0010;
        bus.clear  = 4'b0000;
        #1;
        check("reset_strb",    32'(bus.edge_strb), 32'h0);
        check("reset_pending", 32'(bus.pending),   32'h0);
        check("reset_level",   32'(bus.level),     32'h0);
        check("reset_irq",     32'(bus.irq),       32'h0);
        tick();
        tick();
        reset = 1'b0;

        // ch1 rises with fall-only mode: level follows, no strobe anywhere
        run_watch(1, 10, first, cnt);
        check("ch1_rise_nostrb", 32'(cnt), 32'd0);
        check("ch1_level_up",    32'(bus.level), 32'h2);
        check("ch1_rise_nopend", 32'(bus.pending), 32'h0);

        // 1. ch0 rise -> strobe in the cycle after edge 6
        bus.signal[0] = 1'b1;
        run_watch(0, 12, first, cnt);
        check("t1_first", 32'(first), 32'd7);
        check("t1_count", 32'(cnt), 32'd1);
        check("t1_pending", 32'(bus.pending), 32'h1);
        check("t1_irq", 32'(bus.irq), 32'h1);
        check("t1_level", 32'(bus.level), 32'h3);

        // 2. ch1 3-cycle low glitch ignored, then held fall gives one strobe
        bus.signal[1] = 1'b0;
        run_watch(1, 3, first, cnt);
        bus.signal[1] = 1'b1;
        run_watch(1, 12, first2, cnt2);
        check("t2_glitch_count", 32'(cnt + cnt2), 32'd0);
        check("t2_glitch_level", 32'(bus.level), 32'h3);
        bus.signal[1] = 1'b0;
        run_watch(1, 12, first, cnt);
        check("t2_fall_first", 32'(first), 32'd7);
        check("t2_fall_count", 32'(cnt), 32'd1);
        check("t2_level", 32'(bus.level), 32'h1);
        check("t2_pending", 32'(bus.pending), 32'h3);

        // 3. ch2 square wave period 20, both edges
        abs_t = 0;
        for (int h = 0; h < 4; h++) begin
            bus.signal[2] = ~bus.signal[2];
            for (int t = 0; t < 10; t++) begin
                tick();
                abs_t++;
                if (bus.edge_strb[2]) hits.push_back(abs_t);
            end
        end
        check("t3_count", 32'(hits.size()), 32'd4);
        if (hits.size() == 4) begin
            check("t3_first", 32'(hits[0]), 32'd7);
            for (int k = 1; k < 4; k++) check("t3_gap", 32'(hits[k] - hits[k-1]), 32'd10);
        end
        check("t3_pending", 32'(bus.pending), 32'h7);
        check("t3_level", 32'(bus.level), 32'h1);

        // 4. clear handling and strobe/clear collision on ch0
        bus.clear = 4'b0001;
        tick();
        bus.clear = 4'b0000;
        check("t4_clear0", 32'(bus.pending), 32'h6);
        bus.signal[0] = 1'b0;
        run_watch(0, 12, first, cnt);
        check("t4_fall_masked", 32'(cnt), 32'd0);
        bus.signal[0] = 1'b1;
        run_watch(0, 6, first, cnt);
        check("t4_pre_strb", 32'(cnt), 32'd0);
        tick();
        check("t4_strb", 32'(bus.edge_strb), 32'h1);
        bus.clear = 4'b0001;
        tick();
        bus.clear = 4'b0000;
        check("t4_collide_pend", 32'(bus.pending), 32'h7);
        check("t4_strb_done", 32'(bus.edge_strb), 32'h0);
        bus.clear = 4'b0001;
        tick();
        check("t4_clear_alone", 32'(bus.pending), 32'h6);
        check("t4_irq_still", 32'(bus.irq), 32'h1);
        bus.clear = 4'b0110;
        tick();
        check("t4_all_clear", 32'(bus.pending), 32'h0);
        check("t4_irq_low", 32'(bus.irq), 32'h0);
        bus.clear = 4'b1111;
        tick();
        bus.clear = 4'b0000;
        check("t4_idle_clear", 32'(bus.pending), 32'h0);

        // 5. ch3 edge while disabled, then re-enable; then mode off
        bus.enable = 1'b0;
        bus.signal[3] = 1'b1;
        run_watch(3, 12, first, cnt);
        check("t5_dis_strb", 32'(cnt), 32'd0);
        check("t5_dis_pend", 32'(bus.pending), 32'h0);
        check("t5_dis_level", 32'(bus.level), 32'h9);
        bus.enable = 1'b1;
        run_watch(3, 10, first, cnt);
        check("t5_reen_strb", 32'(cnt), 32'd0);
        check("t5_reen_pend", 32'(bus.pending), 32'h0);
        bus.mode = 8'h39;
        bus.signal[3] = 1'b0;
        run_watch(3, 12, first, cnt);
        check("t5_off_strb", 32'(cnt), 32'd0);
        check("t5_off_pend", 32'(bus.pending), 32'h0);
        check("t5_off_level", 32'(bus.level), 32'h1);

        // 6. reset mid-debounce on ch0 with ch2 state live
        bus.signal = 4'b0100;
        run_watch(2, 12, first, cnt);
        check("t6_pre_pend", 32'(bus.pending), 32'h4);
        check("t6_pre_level", 32'(bus.level), 32'h4);
        bus.signal[0] = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        reset = 1'b1;
        #1;
        check("t6_rst_level", 32'(bus.level), 32'h0);
        check("t6_rst_pend", 32'(bus.pending), 32'h0);
        check("t6_rst_irq", 32'(bus.irq), 32'h0);
        check("t6_rst_strb", 32'(bus.edge_strb), 32'h0);
        tick();
        reset = 1'b0;
        run_watch(0, 12, first, cnt);
        check("t6_first", 32'(first), 32'd7);
        check("t6_count", 32'(cnt), 32'd1);
        check("t6_level", 32'(bus.level), 32'h5);
        check("t6_pend", 32'(bus.pending), 32'h5);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
